// File: rtl/spi_flash_emu_pkg.sv
// Shared constants for the SPI flash emulator: fetch FSM encodings,
// address/counter widths and the byte-lane select helper.
package spi_flash_emu_pkg;

  localparam int EMU_AW = 22;
  localparam int EMU_CW = 16;
  localparam int LANE_W = 2;

  localparam logic [0:0] EMU_IDLE = 1'b0;
  localparam logic [0:0] EMU_REQ  = 1'b1;

  // Lane 0 selects the least significant byte of the word.
  function automatic logic [7:0] lane_byte(
    input logic [31:0]       w,
    input logic [LANE_W-1:0] lane
  );
    return w[{lane, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/spi_flash_emu_if.sv
// Backing-memory read bus: req held until a 1-cycle ack that
// carries rdata. master = requester, slave = memory.
interface spi_flash_emu_if
  import spi_flash_emu_pkg::*;
#(
  parameter int AW = EMU_AW
);

  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [31:0]   mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );

endinterface

// File: rtl/spi_byte_shifter.sv
// 8-bit load/shift register driving SO MSB-first.
// Ports: clk, reset, clear (forces idle 8'hFF), load, shift, din, so_out.
module spi_byte_shifter (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       load,
  input  logic       shift,
  input  logic [7:0] din,
  output logic       so_out
);

  logic [7:0] sreg;
  logic [7:0] sreg_nxt;

  // clear beats load, load beats shift; shifting fills with 1s
  always_comb begin
    sreg_nxt = sreg;
    priority case (1'b1)
      clear:   sreg_nxt = 8'hFF;
      load:    sreg_nxt = din;
      shift:   sreg_nxt = {sreg[6:0], 1'b1};
      default: sreg_nxt = sreg;
    endcase
  end

  // so_out tracks the next MSB so it is visible one clock after load/shift
  always_ff @(posedge clk) begin
    if (reset) begin
      sreg   <= 8'hFF;
      so_out <= 1'b1;
    end else begin
      sreg   <= sreg_nxt;
      so_out <= sreg_nxt[7];
    end
  end

endmodule

// File: rtl/spi_flash_emu.sv
// Fetches the tracked flash word on address change and substitutes SO.
// Ports: clk, reset, enable, addr_hi/addr_lo/addr_changed/load/shift
// from the sniffer, mem (memory read bus), so_out, underrun, underrun_cnt.
module spi_flash_emu
  import spi_flash_emu_pkg::*;
#(
  parameter int MEM_AW = EMU_AW,
  parameter int UCNT_W = EMU_CW
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [MEM_AW-1:0]   addr_hi,
  input  logic [LANE_W-1:0]   addr_lo,
  input  logic                addr_changed,
  input  logic                load,
  input  logic                shift,
  spi_flash_emu_if.master     mem,
  output logic                so_out,
  output logic                underrun,
  output logic [UCNT_W-1:0]   underrun_cnt
);

  logic [0:0]        state;
  logic              req_q;
  logic [MEM_AW-1:0] addr_q;
  logic [31:0]       word;
  logic [MEM_AW-1:0] word_addr;
  logic              word_valid;
  logic              refetch;
  logic              hit;
  logic              miss;
  logic [7:0]        byte_sel;

  assign mem.mem_req  = req_q;
  assign mem.mem_addr = addr_q;

  assign hit      = word_valid && (word_addr == addr_hi);
  assign miss     = enable && load && !hit;
  assign byte_sel = hit ? lane_byte(word, addr_lo) : 8'hFF;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= EMU_IDLE;
      req_q        <= 1'b0;
      addr_q       <= '0;
      word         <= '0;
      word_addr    <= '0;
      word_valid   <= 1'b0;
      refetch      <= 1'b0;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else if (!enable) begin
      // abandon any outstanding request; a late ack lands in IDLE
      state      <= EMU_IDLE;
      req_q      <= 1'b0;
      word_valid <= 1'b0;
      refetch    <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      underrun <= miss;
      if (miss && (underrun_cnt != '1))
        underrun_cnt <= underrun_cnt + 1'b1;

      unique case (state)
        EMU_IDLE: begin
          if (addr_changed) begin
            state      <= EMU_REQ;
            req_q      <= 1'b1;
            addr_q     <= addr_hi;
            word_valid <= 1'b0;
          end
        end
        EMU_REQ: begin
          if (mem.mem_ack) begin
            if (refetch || addr_changed) begin
              // stale data: reissue for the current address, req stays high
              addr_q  <= addr_hi;
              refetch <= 1'b0;
            end else begin
              word       <= mem.mem_rdata;
              word_addr  <= addr_q;
              word_valid <= 1'b1;
              req_q      <= 1'b0;
              state      <= EMU_IDLE;
            end
          end else if (addr_changed) begin
            refetch    <= 1'b1;
            word_valid <= 1'b0;
          end
        end
        default: begin
          state <= EMU_IDLE;
          req_q <= 1'b0;
        end
      endcase
    end
  end

  spi_byte_shifter u_shifter (
    .clk    (clk),
    .reset  (reset),
    .clear  (!enable),
    .load   (load && enable),
    .shift  (shift),
    .din    (byte_sel),
    .so_out (so_out)
  );

endmodule

// File: tb/tb_spi_flash_emu.sv
// Randomized self-checking bench for spi_flash_emu against a
// byte-lane / saturating-count reference model.
module tb_spi_flash_emu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [21:0] addr_hi = '0;
  logic [1:0]  addr_lo = '0;
  logic        addr_changed = 1'b0;
  logic        load = 1'b0;
  logic        shift = 1'b0;
  logic        so_out, underrun;
  logic [15:0] underrun_cnt;
  logic        s_so_out, s_underrun;
  logic [3:0]  s_cnt;

  int total = 0;
  int bad = 0;
  int exp_cnt = 0;
  int sat_exp = 0;

  always #5 clk = ~clk;

  spi_flash_emu_if bus ();
  spi_flash_emu_if sbus ();

  assign sbus.mem_ack   = 1'b0;
  assign sbus.mem_rdata = '0;

  spi_flash_emu dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .addr_hi      (addr_hi),
    .addr_lo      (addr_lo),
    .addr_changed (addr_changed),
    .load         (load),
    .shift        (shift),
    .mem          (bus.master),
    .so_out       (so_out),
    .underrun     (underrun),
    .underrun_cnt (underrun_cnt)
  );

  // narrow counter instance; its memory never answers, so every load misses
  spi_flash_emu #(.UCNT_W(4)) dut_sat (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .addr_hi      (addr_hi),
    .addr_lo      (addr_lo),
    .addr_changed (addr_changed),
    .load         (load),
    .shift        (shift),
    .mem          (sbus.master),
    .so_out       (s_so_out),
    .underrun     (s_underrun),
    .underrun_cnt (s_cnt)
  );

  always @(posedge clk)
    if (reset) sat_exp <= 0;
    else if (enable && load) sat_exp <= (sat_exp >= 15) ? 15 : sat_exp + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] ref_byte(logic [31:0] w, int lane);
    logic [31:0] s;
    s = w >> (8 * lane);
    return s[7:0];
  endfunction

  function automatic logic [21:0] rnd_addr();
    return 22'($urandom);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // load one byte (optionally with shift in the same cycle) then 7 shifts
  task automatic read_byte(input logic [1:0] lane, input bit with_shift,
                           output logic [7:0] got, output logic ur);
    addr_lo = lane;
    load = 1'b1;
    shift = with_shift;
    tick();
    got[7] = so_out;
    ur = underrun;
    load = 1'b0;
    shift = 1'b1;
    for (int i = 6; i >= 0; i--) begin
      tick();
      got[i] = so_out;
    end
    shift = 1'b0;
  endtask

  task automatic fetch(input logic [21:0] a, input logic [31:0] d, input int lat);
    addr_hi = a;
    addr_changed = 1'b1;
    tick();
    addr_changed = 1'b0;
    repeat (lat - 1) tick();
    bus.mem_ack = 1'b1;
    bus.mem_rdata = d;
    tick();
    bus.mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    enable = 1'b1;
    addr_changed = 1'b1;
    repeat (3) tick();
    total++; if (bus.mem_req !== 1'b0) begin bad++;
      $display("FAIL reset_req got=%b exp=0", bus.mem_req); end
    total++; if (bus.mem_addr !== 22'd0) begin bad++;
      $display("FAIL reset_addr got=%h exp=0", bus.mem_addr); end
    total++; if (so_out !== 1'b1) begin bad++;
      $display("FAIL reset_so got=%b exp=1", so_out); end
    total++; if (underrun !== 1'b0) begin bad++;
      $display("FAIL reset_underrun got=%b exp=0", underrun); end
    total++; if (underrun_cnt !== 16'd0) begin bad++;
      $display("FAIL reset_cnt got=%0d exp=0", underrun_cnt); end
    total++; if (s_cnt !== 4'd0) begin bad++;
      $display("FAIL reset_sat_cnt got=%0d exp=0", s_cnt); end
    addr_changed = 1'b0;
    reset = 1'b0;
    exp_cnt = 0;
    tick();
  endtask

  task automatic test_fetch();
    logic [21:0] a;
    logic [31:0] d;
    logic [1:0]  lane;
    logic [7:0]  got;
    logic        ur;
    for (int r = 0; r < 4; r++) begin
      a = (r == 0) ? 22'h000010 : rnd_addr();
      d = (r == 0) ? 32'hA1B2C3D4 : $urandom;
      lane = (r == 0) ? 2'd1 : 2'($urandom_range(3));
      addr_hi = a;
      addr_changed = 1'b1;
      tick();
      addr_changed = 1'b0;
      for (int k = 0; k < 3; k++) begin
        total++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== a) begin bad++;
          $display("FAIL fetch_req r=%0d got=%b/%h exp=1/%h",
                   r, bus.mem_req, bus.mem_addr, a); end
        if (k < 2) tick();
      end
      bus.mem_ack = 1'b1;
      bus.mem_rdata = d;
      tick();
      bus.mem_ack = 1'b0;
      total++; if (bus.mem_req !== 1'b0) begin bad++;
        $display("FAIL fetch_req_drop r=%0d got=%b exp=0", r, bus.mem_req); end
      read_byte(lane, r == 2, got, ur);
      total++; if (got !== ref_byte(d, int'(lane))) begin bad++;
        $display("FAIL fetch_byte r=%0d got=%h exp=%h", r, got, ref_byte(d, int'(lane))); end
      total++; if (ur !== 1'b0) begin bad++;
        $display("FAIL fetch_underrun r=%0d got=%b exp=0", r, ur); end
      shift = 1'b1;
      tick();
      shift = 1'b0;
      total++; if (so_out !== 1'b1) begin bad++;
        $display("FAIL fetch_fill r=%0d got=%b exp=1", r, so_out); end
      total++; if (underrun_cnt !== 16'(exp_cnt)) begin bad++;
        $display("FAIL fetch_cnt r=%0d got=%0d exp=%0d", r, underrun_cnt, exp_cnt); end
    end
  endtask

  task automatic test_underrun();
    logic [21:0] a;
    logic [31:0] d;
    logic [1:0]  lane;
    logic [7:0]  got;
    logic        ur;
    int          lat;
    for (int r = 0; r < 3; r++) begin
      a = addr_hi ^ (rnd_addr() | 22'd1);
      d = $urandom;
      lane = 2'($urandom_range(3));
      lat = (r == 0) ? 20 : int'($urandom_range(12, 25));
      addr_hi = a;
      addr_changed = 1'b1;
      tick();
      addr_changed = 1'b0;
      read_byte(lane, 1'b0, got, ur);
      exp_cnt++;
      total++; if (ur !== 1'b1) begin bad++;
        $display("FAIL early_underrun r=%0d got=%b exp=1", r, ur); end
      total++; if (got !== 8'hFF) begin bad++;
        $display("FAIL early_byte r=%0d got=%h exp=ff", r, got); end
      total++; if (underrun !== 1'b0 || underrun_cnt !== 16'(exp_cnt)) begin bad++;
        $display("FAIL early_cnt r=%0d got=%b/%0d exp=0/%0d",
                 r, underrun, underrun_cnt, exp_cnt); end
      repeat (lat - 9) tick();
      bus.mem_ack = 1'b1;
      bus.mem_rdata = d;
      tick();
      bus.mem_ack = 1'b0;
      read_byte(lane, 1'b0, got, ur);
      total++; if (got !== ref_byte(d, int'(lane)) || ur !== 1'b0) begin bad++;
        $display("FAIL late_byte r=%0d got=%h/%b exp=%h/0",
                 r, got, ur, ref_byte(d, int'(lane))); end
    end
  endtask

  task automatic test_refetch();
    logic [21:0] a, b;
    logic [31:0] d1, d2;
    logic [1:0]  lane;
    logic [7:0]  got;
    logic        ur;
    for (int r = 0; r < 3; r++) begin
      a = (r == 0) ? 22'h10 : rnd_addr();
      b = (r == 0) ? 22'h20 : a ^ (rnd_addr() | 22'd1);
      d1 = $urandom;
      d2 = ~d1;
      lane = 2'($urandom_range(3));
      addr_hi = a;
      addr_changed = 1'b1;
      tick();
      addr_changed = 1'b0;
      tick();
      addr_hi = b;
      addr_changed = 1'b1;
      tick();
      addr_changed = 1'b0;
      total++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== a) begin bad++;
        $display("FAIL refetch_hold r=%0d got=%b/%h exp=1/%h",
                 r, bus.mem_req, bus.mem_addr, a); end
      bus.mem_ack = 1'b1;
      bus.mem_rdata = d1;
      tick();
      bus.mem_ack = 1'b0;
      total++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== b) begin bad++;
        $display("FAIL refetch_reissue r=%0d got=%b/%h exp=1/%h",
                 r, bus.mem_req, bus.mem_addr, b); end
      tick();
      bus.mem_ack = 1'b1;
      bus.mem_rdata = d2;
      tick();
      bus.mem_ack = 1'b0;
      total++; if (bus.mem_req !== 1'b0) begin bad++;
        $display("FAIL refetch_done r=%0d got=%b exp=0", r, bus.mem_req); end
      read_byte(lane, 1'b0, got, ur);
      total++; if (got !== ref_byte(d2, int'(lane)) || ur !== 1'b0) begin bad++;
        $display("FAIL refetch_byte r=%0d got=%h/%b exp=%h/0",
                 r, got, ur, ref_byte(d2, int'(lane))); end
    end
  endtask

  task automatic test_collide();
    logic [21:0] a, b;
    logic [31:0] d1, d2;
    logic [1:0]  lane;
    logic [7:0]  got;
    logic        ur;
    for (int r = 0; r < 3; r++) begin
      a = rnd_addr();
      b = a ^ (rnd_addr() | 22'd1);
      d1 = $urandom;
      d2 = d1 ^ 32'h5A5A_A5A5;
      lane = 2'($urandom_range(3));
      addr_hi = a;
      addr_changed = 1'b1;
      tick();
      addr_changed = 1'b0;
      tick();
      addr_hi = b;
      addr_changed = 1'b1;
      bus.mem_ack = 1'b1;
      bus.mem_rdata = d1;
      tick();
      addr_changed = 1'b0;
      bus.mem_ack = 1'b0;
      for (int k = 0; k < 2; k++) begin
        total++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== b) begin bad++;
          $display("FAIL collide_req r=%0d k=%0d got=%b/%h exp=1/%h",
                   r, k, bus.mem_req, bus.mem_addr, b); end
        if (k == 0) tick();
      end
      bus.mem_ack = 1'b1;
      bus.mem_rdata = d2;
      tick();
      bus.mem_ack = 1'b0;
      read_byte(lane, 1'b0, got, ur);
      total++; if (got !== ref_byte(d2, int'(lane)) || ur !== 1'b0) begin bad++;
        $display("FAIL collide_byte r=%0d got=%h/%b exp=%h/0",
                 r, got, ur, ref_byte(d2, int'(lane))); end
    end
  endtask

  task automatic test_enable();
    logic [21:0] c;
    logic [7:0]  got;
    logic        ur;
    c = addr_hi ^ 22'h155;
    addr_hi = c;
    addr_changed = 1'b1;
    tick();
    addr_changed = 1'b0;
    enable = 1'b0;
    tick();
    total++; if (bus.mem_req !== 1'b0 || so_out !== 1'b1) begin bad++;
      $display("FAIL en_drop got=%b/%b exp=0/1", bus.mem_req, so_out); end
    load = 1'b1;
    tick();
    load = 1'b0;
    total++; if (underrun !== 1'b0 || underrun_cnt !== 16'(exp_cnt)) begin bad++;
      $display("FAIL en_nocount got=%b/%0d exp=0/%0d", underrun, underrun_cnt, exp_cnt); end
    enable = 1'b1;
    bus.mem_ack = 1'b1;
    bus.mem_rdata = $urandom;
    tick();
    bus.mem_ack = 1'b0;
    total++; if (bus.mem_req !== 1'b0) begin bad++;
      $display("FAIL en_late_ack got=%b exp=0", bus.mem_req); end
    read_byte(2'd0, 1'b0, got, ur);
    exp_cnt++;
    total++; if (got !== 8'hFF || ur !== 1'b1 || underrun_cnt !== 16'(exp_cnt)) begin bad++;
      $display("FAIL en_stale got=%h/%b/%0d exp=ff/1/%0d", got, ur, underrun_cnt, exp_cnt); end
    fetch(c, 32'h0, 4);
    addr_lo = 2'($urandom_range(3));
    load = 1'b1;
    tick();
    load = 1'b0;
    total++; if (so_out !== 1'b0) begin bad++;
      $display("FAIL en_zero_byte got=%b exp=0", so_out); end
    enable = 1'b0;
    tick();
    total++; if (so_out !== 1'b1) begin bad++;
      $display("FAIL en_so_idle got=%b exp=1", so_out); end
    enable = 1'b1;
    read_byte(2'd1, 1'b0, got, ur);
    exp_cnt++;
    total++; if (got !== 8'hFF || ur !== 1'b1) begin bad++;
      $display("FAIL en_invalid got=%h/%b exp=ff/1", got, ur); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] got;
    logic       ur;
    addr_hi = rnd_addr();
    addr_changed = 1'b1;
    tick();
    addr_changed = 1'b0;
    total++; if (bus.mem_req !== 1'b1) begin bad++;
      $display("FAIL rmid_req got=%b exp=1", bus.mem_req); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_cnt = 0;
    total++; if (bus.mem_req !== 1'b0 || so_out !== 1'b1 || underrun_cnt !== 16'd0) begin
      bad++;
      $display("FAIL rmid_state got=%b/%b/%0d exp=0/1/0", bus.mem_req, so_out, underrun_cnt);
    end
    bus.mem_ack = 1'b1;
    bus.mem_rdata = $urandom;
    tick();
    bus.mem_ack = 1'b0;
    total++; if (bus.mem_req !== 1'b0) begin bad++;
      $display("FAIL rmid_late_ack got=%b exp=0", bus.mem_req); end
    read_byte(2'd3, 1'b0, got, ur);
    exp_cnt++;
    total++; if (got !== 8'hFF || ur !== 1'b1 || underrun_cnt !== 16'(exp_cnt)) begin bad++;
      $display("FAIL rmid_invalid got=%h/%b/%0d exp=ff/1/%0d", got, ur, underrun_cnt, exp_cnt);
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 20; i++) begin
      load = 1'b1;
      tick();
      exp_cnt++;
      total++; if (s_underrun !== 1'b1 || s_cnt !== 4'(sat_exp)) begin bad++;
        $display("FAIL sat_step i=%0d got=%b/%0d exp=1/%0d", i, s_underrun, s_cnt, sat_exp);
      end
    end
    load = 1'b0;
    tick();
    total++; if (s_cnt !== 4'hF) begin bad++;
      $display("FAIL sat_hold got=%0d exp=15", s_cnt); end
    total++; if (underrun_cnt !== 16'(exp_cnt)) begin bad++;
      $display("FAIL sat_main_cnt got=%0d exp=%0d", underrun_cnt, exp_cnt); end
  endtask

  initial begin
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    test_reset();
    test_fetch();
    test_underrun();
    test_refetch();
    test_collide();
    test_enable();
    test_reset_mid();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
